// File: rtl/trigger_sample_queue.sv
// Trigger-driven byte sampler front end: synchronises pins, captures a byte on each
// trigger rising edge into a FIFO and drains it to the avr_interface serial handshake.
module trigger_sample_queue #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit HEX_MODE    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               data_in,
    input  logic                     trig_in,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy,
    input  logic                     clr_ovf,
    output logic [7:0]               overflow_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, SEND_HI, SEND_LO, SEND_NL, GAP} state_t;

    logic [SYNC_STAGES-1:0][7:0] data_sync_q;
    logic [SYNC_STAGES-1:0]      trig_sync_q;
    logic [SYNC_STAGES-1:0]      warm_q;
    logic                        trig_prev_q;
    logic [7:0]                  data_sync;
    logic                        trig_sync;
    logic                        capture;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full, empty, push, drop, pop;
    logic [7:0]    ovf_q, ovf_d;

    state_t        state_q, state_d, after_gap_q, after_gap_d;
    logic [7:0]    hold_q, hold_d;

    assign data_sync = data_sync_q[SYNC_STAGES-1];
    assign trig_sync = trig_sync_q[SYNC_STAGES-1];
    assign capture   = trig_sync & ~trig_prev_q;

    // trig_prev stays at 1 until the synchroniser has filled, so a pin held high
    // through reset release is never seen as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q <= '0;
            trig_sync_q <= '0;
            warm_q      <= '0;
            trig_prev_q <= 1'b1;
        end else begin
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_in};
            trig_sync_q <= {trig_sync_q[SYNC_STAGES-2:0], trig_in};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            trig_prev_q <= warm_q[SYNC_STAGES-1] ? trig_sync : 1'b1;
        end
    end

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = capture & ~full;
    assign drop  = capture & full;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_sync;
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)                   ovf_d = {7'd0, drop};
        else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // The head byte is latched on the pop edge: once popped, its slot may be
    // refilled by a capture during FETCH.
    always_comb begin
        state_d     = state_q;
        after_gap_d = after_gap_q;
        hold_d      = hold_q;
        pop         = 1'b0;
        tx_data     = 8'h00;
        new_tx_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    state_d = FETCH;
                end
            end
            FETCH: state_d = SEND_HI;
            SEND_HI: begin
                tx_data     = HEX_MODE ? hex_char(hold_q[7:4]) : hold_q;
                new_tx_data = ~tx_busy;
                if (!tx_busy) begin
                    state_d     = GAP;
                    after_gap_d = HEX_MODE ? SEND_LO : IDLE;
                end
            end
            SEND_LO: begin
                tx_data     = hex_char(hold_q[3:0]);
                new_tx_data = ~tx_busy;
                if (!tx_busy) begin
                    state_d     = GAP;
                    after_gap_d = SEND_NL;
                end
            end
            SEND_NL: begin
                tx_data     = 8'h0A;
                new_tx_data = ~tx_busy;
                if (!tx_busy) begin
                    state_d     = GAP;
                    after_gap_d = IDLE;
                end
            end
            GAP:     state_d = after_gap_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            after_gap_q <= IDLE;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            hold_q      <= hold_d;
        end
    end

    assign overflow_count = ovf_q;
    assign fifo_level     = level_q;
endmodule

// File: tb/tb_trigger_sample_queue.sv
// Directed/random bench for trigger_sample_queue: a hex-mode and a raw-mode
// instance share the same pins; transmitted bytes are collected and compared.
module tb_trigger_sample_queue;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       trig_in = 1'b0;
    logic       tx_busy = 1'b0;
    logic       clr_ovf = 1'b0;

    logic [7:0] tx_data_h, tx_data_r, ovf_h, ovf_r;
    logic       new_h, new_r;
    logic [4:0] lvl_h, lvl_r;

    trigger_sample_queue #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .HEX_MODE(1'b1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .trig_in(trig_in),
        .tx_data(tx_data_h), .new_tx_data(new_h), .tx_busy(tx_busy),
        .clr_ovf(clr_ovf), .overflow_count(ovf_h), .fifo_level(lvl_h));

    trigger_sample_queue #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .HEX_MODE(1'b0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .trig_in(trig_in),
        .tx_data(tx_data_r), .new_tx_data(new_r), .tx_busy(tx_busy),
        .clr_ovf(clr_ovf), .overflow_count(ovf_r), .fifo_level(lvl_r));

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] got_h[$];
    logic [7:0] got_r[$];
    int         got_h_cyc[$];
    logic [7:0] exp_q[$];
    int         viol = 0;
    logic       prev_h = 1'b0, prev_r = 1'b0;

    always @(negedge clk) begin
        if (new_h) begin
            got_h.push_back(tx_data_h);
            got_h_cyc.push_back(cyc);
        end
        if (new_r) got_r.push_back(tx_data_r);
        if ((new_h | new_r) & tx_busy) viol++;
        if ((new_h & prev_h) | (new_r & prev_r)) viol++;
        prev_h = new_h;
        prev_r = new_r;
    end

    int checks = 0;
    int errors = 0;
    bit rand_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        string s;
        s = "0123456789ABCDEF";
        return s[n];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_busy) tx_busy = 1'($urandom_range(0, 1));
    endtask

    // Rising edge on the trigger pin with data held; optional clr_ovf in the capture cycle.
    task automatic trig_edge(input logic [7:0] d, input bit clr);
        data_in = d;
        trig_in = 1'b1;
        tick();
        tick();
        clr_ovf = clr;
        trig_in = 1'b0;
        tick();
        clr_ovf = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_hex(input int n, input int budget);
        for (int i = 0; i < budget && got_h.size() < n; i++) tick();
    endtask

    initial begin
        int t0;
        logic [7:0] d;

        // Reset with trigger held high through release.
        trig_in = 1'b1;
        data_in = 8'h55;
        repeat (3) tick();
        check("rst_tx_data", tx_data_h, 8'h00);
        check("rst_new_tx", new_h, 1'b0);
        check("rst_level", lvl_h, 5'd0);
        check("rst_ovf", ovf_h, 8'd0);
        rst_n = 1'b1;
        repeat (12) tick();
        check("hold_high_level", lvl_h, 5'd0);
        check("hold_high_no_tx", got_h.size(), 0);
        trig_in = 1'b0;
        repeat (4) tick();

        // Single sample 0xA5 in hex mode, transmitter idle.
        got_h.delete(); got_h_cyc.delete(); got_r.delete();
        t0 = cyc;
        trig_edge(8'hA5, 1'b0);
        wait_hex(3, 40);
        repeat (10) tick();
        check("a5_count", got_h.size(), 3);
        check("a5_hi", got_h[0], 8'h41);
        check("a5_lo", got_h[1], 8'h35);
        check("a5_nl", got_h[2], 8'h0A);
        check("a5_latency", got_h_cyc[0] - t0, SYNC + 3);
        check("a5_gap1", got_h_cyc[1] - got_h_cyc[0], 2);
        check("a5_gap2", got_h_cyc[2] - got_h_cyc[1], 2);
        check("a5_raw", got_r[0], 8'hA5);
        check("a5_level", lvl_h, 5'd0);

        // Burst of 20 with the transmitter busy: 16 buffered, 4 dropped.
        got_h.delete(); exp_q.delete();
        tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) trig_edge(8'(i), 1'b0);
        repeat (4) tick();
        check("burst_level", lvl_h, 5'd16);
        check("burst_ovf", ovf_h, 8'd4);
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i);
            exp_q.push_back(hex_ch(d[7:4]));
            exp_q.push_back(hex_ch(d[3:0]));
            exp_q.push_back(8'h0A);
        end
        tx_busy = 1'b0;
        wait_hex(exp_q.size(), 400);
        repeat (30) tick();
        check("burst_tx_count", got_h.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) check($sformatf("burst_tx[%0d]", k), got_h[k], exp_q[k]);
        check("burst_drained", lvl_h, 5'd0);

        // Overflow counter: reach 7, clear coincident with a drop, then saturate.
        tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) trig_edge(8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) trig_edge(8'hF0, 1'b0);
        check("ovf_seven", ovf_h, 8'd7);
        trig_edge(8'hEE, 1'b1);
        check("ovf_clr_drop", ovf_h, 8'd1);
        for (int i = 0; i < 300; i++) trig_edge(8'(i), 1'b0);
        check("ovf_saturate", ovf_h, 8'd255);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_clear", ovf_h, 8'd0);

        // Raw mode with a randomly toggling busy line.
        tx_busy = 1'b0;
        do_reset();
        got_r.delete(); exp_q.delete();
        rand_busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            d = 8'($urandom);
            trig_edge(d, 1'b0);
            exp_q.push_back(d);
            repeat ($urandom_range(4, 10)) tick();
        end
        for (int i = 0; i < 2000 && got_r.size() < 50; i++) tick();
        rand_busy = 1'b0;
        tx_busy = 1'b0;
        repeat (20) tick();
        check("raw_ovf", ovf_r, 8'd0);
        check("raw_count", got_r.size(), 50);
        for (int k = 0; k < 50; k++) check($sformatf("raw_tx[%0d]", k), got_r[k], exp_q[k]);

        // Reset while parked in the low-nibble send with 3 samples queued.
        do_reset();
        got_h.delete();
        trig_edge(8'hA5, 1'b0);
        wait_hex(1, 30);
        tx_busy = 1'b1;
        trig_edge(8'h11, 1'b0);
        trig_edge(8'h22, 1'b0);
        trig_edge(8'h33, 1'b0);
        repeat (2) tick();
        check("mid_level", lvl_h, 5'd3);
        check("mid_tx_data", tx_data_h, 8'h35);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_data", tx_data_h, 8'h00);
        check("mid_rst_new_tx", new_h, 1'b0);
        check("mid_rst_level", lvl_h, 5'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tx_busy = 1'b0;
        repeat (60) tick();
        check("post_rst_tx_count", got_h.size(), 1);
        check("post_rst_level", lvl_h, 5'd0);

        check("strobe_protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_sample_queue.md
Name: trigger_sample_queue

Overview:
Capture front end for the level-translator byte sampler. Synchronises the 8 data pins and the trigger pin, and captures one byte on each trigger rising edge into a FIFO. Drains the FIFO into the serial transmit handshake of avr_interface (tx_data / new_tx_data / tx_busy). Bursts of triggers arriving faster than the UART can send are buffered rather than lost, and dropped samples are counted.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
SYNC_STAGES, 2, synchroniser flops on data_in and trig_in; minimum 2
HEX_MODE, 1, 1 = send each sample as two uppercase ASCII hex chars plus 0x0A; 0 = send the raw byte

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous, active-low reset
data_in  in  8  raw sample pins, asynchronous
trig_in  in  1  raw trigger pin, asynchronous
tx_data  out  8  byte to avr_interface
new_tx_data  out  1  single-cycle strobe; tx_data is valid in the same cycle
tx_busy  in  1  avr_interface transmitter busy
clr_ovf  in  1  synchronous clear of overflow_count
overflow_count  out  8  dropped-sample count, saturates at 255
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx_data=0, new_tx_data=0, overflow_count=0, fifo_level=0.
  - FIFO pointers cleared; synchroniser flops cleared to 0.
  - Trigger-previous register set to 1, so a trigger held high through reset release does not capture.
  - FSM returns to IDLE. A reset mid-character discards the current and all queued samples.
- Synchronisation: data_in and trig_in each pass through SYNC_STAGES flops. Data and trigger use equal depth so they stay aligned.
- Edge detect:
  - capture = trig_sync & ~trig_prev; trig_prev <= trig_sync every cycle.
  - The captured byte is data_sync in the capture cycle.
  - Latency from pin edge to FIFO write is SYNC_STAGES+1 cycles.
- Write:
  - On capture with FIFO not full, write the byte; fifo_level increments the next cycle.
  - On capture with FIFO full, drop the byte; overflow_count increments, saturating at 255.
  - Fullness is evaluated before any same-cycle pop, so capture while full is always dropped.
- Simultaneous push and pop (not full): fifo_level unchanged.
- Pointers wrap modulo DEPTH. full = level==DEPTH; empty = level==0.
- clr_ovf: overflow_count <= 0. If clr_ovf and a drop occur in the same cycle, the result is 1.
- Drain FSM, states IDLE, FETCH, SEND_HI, SEND_LO, SEND_NL, GAP:
  - IDLE: when not empty, pop; go to FETCH.
  - FETCH: head byte latched into hold register; go to SEND_HI, or SEND_RAW when HEX_MODE=0 (SEND_HI doubles as SEND_RAW).
  - SEND_x: when tx_busy==0, drive tx_data and pulse new_tx_data for 1 cycle, then go to GAP. While tx_busy==1, hold with no strobe.
  - GAP: exactly 1 cycle, covering avr_interface's 1-cycle tx_busy assertion latency. Then go to the next SEND state, or to IDLE after the last character.
  - Character order in HEX_MODE: SEND_HI → SEND_LO → SEND_NL. With HEX_MODE=0: a single SEND.
- Hex encoding: nibble 0–9 → 0x30+n; nibble 10–15 → 0x41+(n−10).
- Strobe spacing: new_tx_data is never asserted in 2 consecutive cycles.
- Timing with tx_busy low: the first strobe occurs 2 cycles after the FIFO write cycle.
- A sample leaves the FIFO only when popped in IDLE. Captures during SEND_x/GAP queue normally.

Test Plan:
1. Reset, then release with trig_in held high → no capture; fifo_level=0; no new_tx_data.
2. HEX_MODE=1, tx_busy=0, data_in=0xA5, single trig rise → strobes 0x41, 0x35, 0x0A in order, each followed by 1 idle cycle; first strobe SYNC_STAGES+3 cycles after the pin edge.
3. tx_busy held high, 20 trigger edges with data 0x00..0x13 (DEPTH=16) → fifo_level=16, overflow_count=4. Release tx_busy → bytes 0x00..0x0F drained in order; 0x10..0x13 never sent.
4. Drop coincident with clr_ovf when overflow_count=7 → count becomes 1. 300 drops without clearing → count saturates at 255.
5. HEX_MODE=0, tx_busy toggling randomly, 50 random-byte triggers → the tx byte stream equals the captured sequence; new_tx_data is never asserted while tx_busy=1 or in consecutive cycles.
6. Assert rst_n low mid-SEND_LO with 3 samples queued → outputs go to 0 immediately; after release, no further strobes and fifo_level=0.
